plic_gateway: RTL and testbench
===============================

PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 SHALL have parameter IRQ_CNT, default 8, number of interrupt sources (legal 1..31), indexed 1..IRQ_CNT.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port src_i  input  [IRQ_CNT:1]  raw device interrupt lines, asynchronous to clk.
REQ-005 SHALL have port edge_i  input  [IRQ_CNT:1]  per-source mode: 1 = rising-edge triggered, 0 = level triggered.
REQ-006 SHALL have port claim_i  input  1  pulse: the interrupt controller claims source claim_id_i this cycle.
REQ-007 SHALL have port claim_id_i  input  [$clog2(IRQ_CNT):0]  claimed source ID; 0 = none.
REQ-008 SHALL have port complete_i  input  1  pulse: the handler signals completion of source complete_id_i.
REQ-009 SHALL have port complete_id_i  input  [$clog2(IRQ_CNT):0]  completed source ID.
REQ-010 SHALL have port irq_o  output  [IRQ_CNT:1]  gated requests; drives the interrupt controller's per-source request input.

Function
REQ-011 SHALL pass each src_i bit through a 2-flop synchronizer (s1, s2), plus a third flop s3 for edge detection.
REQ-012 SHALL keep one FSM per source with states IDLE, PENDING, CLAIMED.
REQ-013 SHALL drive irq_o[i] = 1 exactly when source i is in PENDING, decoded from registered state with no combinational path from any input.
REQ-014 SHALL define the trigger as s2 & ~s3 in edge mode and s2 in level mode.
REQ-015 IDLE: SHALL move to PENDING on trigger; irq_o rises 3 clk edges after src_i rises, counting the first capturing edge.
REQ-016 PENDING: SHALL move to CLAIMED when claim_i=1 and claim_id_i=i; further edges in PENDING merge and are dropped.
REQ-017 CLAIMED: SHALL hold irq_o[i]=0 regardless of src_i; a rising edge in edge mode sets a 1-deep per-source buffer edge_buf[i].
REQ-018 CLAIMED with complete_i=1 and complete_id_i=i: SHALL go to PENDING if (edge mode and (edge_buf or trigger this cycle)) or (level mode and s2=1), else IDLE; edge_buf cleared.
REQ-019 SHALL ignore claim of a source not in PENDING and completion of a source not in CLAIMED.
REQ-020 SHALL ignore claim_id_i / complete_id_i equal to 0 or greater than IRQ_CNT.
REQ-021 Same-cycle claim and complete addressing different sources SHALL both take effect independently.
REQ-022 SHALL clear edge_buf[i] whenever edge_i[i]=0; a mode change SHALL NOT alter the current state.
REQ-023 Additional edges while edge_buf is set SHALL be dropped; edge_buf never counts beyond 1.

Reset
REQ-024 Reset SHALL set every FSM to IDLE, and clear s1, s2, s3 and edge_buf; irq_o = 0 the cycle after reset is sampled.
REQ-025 Reset mid-operation (PENDING or CLAIMED) SHALL abandon the request; a level source still high re-requests 3 cycles after reset deasserts.

Structure
REQ-026 SHALL place the state enum gw_state_e (IDLE, PENDING, CLAIMED) in shared package my_pkg.
REQ-027 SHALL implement per-source logic in sub-module plic_gw_cell, instantiated by a generate loop over 1..IRQ_CNT.
REQ-028 SHALL decode claim_id_i and complete_id_i once in the top level into one-hot vectors fed to the cells.

Verification
REQ-029 Level source 3: src_i[3]=1 at cycle 0 -> irq_o[3]=1 from cycle 3; claim id 3 -> irq_o[3]=0 next cycle; complete id 3 with src still high -> irq_o[3]=1 next cycle.
REQ-030 Edge source 5: one-cycle pulse -> irq_o[5] held high until claim id 5; two pulses while CLAIMED -> exactly one re-request after complete id 5.
REQ-031 Claim id 0, id IRQ_CNT+1, and complete of an IDLE source -> no state change on any source.
REQ-032 Sources 2 and 4 pending; claim 2 and complete 4 (4 previously CLAIMED) in the same cycle -> both transitions occur.
REQ-033 Reset asserted while source 1 is CLAIMED and source 6 is PENDING -> irq_o=0 next cycle; edge_buf cleared; no spurious request after reset.
REQ-034 Edge source 7 CLAIMED with edge_buf set, then edge_i[7] forced to 0, then complete id 7 with src low -> IDLE, irq_o[7] stays 0.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types for the PLIC interrupt gateway.
// Holds the per-source gateway state encoding used by every cell.
package my_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gw_cell.sv
// Single-source gateway: synchronizer, edge detector, IDLE/PENDING/CLAIMED FSM
// and a 1-deep buffer for edges that arrive while the source is being serviced.
module plic_gw_cell
  import my_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic irq
);

  logic      s1;
  logic      s2;
  logic      s3;
  logic      edge_buf;
  gw_state_e state;

  logic rise;
  logic trigger;
  logic requeue;

  assign rise    = s2 & ~s3;
  assign trigger = edge_mode ? rise : s2;
  // On completion, re-request if an edge is banked (or arriving now) or the level is still high.
  assign requeue = edge_mode ? (edge_buf | rise) : s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      edge_buf <= 1'b0;
      state    <= IDLE;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (trigger) state <= PENDING;
        end
        PENDING: begin
          if (claim) state <= CLAIMED;
        end
        CLAIMED: begin
          if (complete) begin
            state    <= requeue ? PENDING : IDLE;
            edge_buf <= 1'b0;
          end else if (edge_mode && rise) begin
            edge_buf <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Level mode never banks edges; this has priority over any set above.
      if (!edge_mode) edge_buf <= 1'b0;
    end
  end

  assign irq = (state == PENDING);

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: decodes claim/complete IDs once and fans the
// one-hot strobes out to one gateway cell per interrupt source.
module plic_gateway
  import my_pkg::*;
#(
  parameter int unsigned IRQ_CNT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IRQ_CNT:1]         src_i,
  input  logic [IRQ_CNT:1]         edge_i,
  input  logic                     claim_i,
  input  logic [$clog2(IRQ_CNT):0] claim_id_i,
  input  logic                     complete_i,
  input  logic [$clog2(IRQ_CNT):0] complete_id_i,
  output logic [IRQ_CNT:1]         irq_o
);

  localparam int unsigned ID_W = $clog2(IRQ_CNT) + 1;

  logic [IRQ_CNT:1] claim_oh;
  logic [IRQ_CNT:1] complete_oh;

  // ID 0 and IDs above IRQ_CNT match no bit, so they are dropped here.
  always_comb begin
    claim_oh    = '0;
    complete_oh = '0;
    for (int unsigned i = 1; i <= IRQ_CNT; i++) begin
      claim_oh[i]    = claim_i    && (claim_id_i    == ID_W'(i));
      complete_oh[i] = complete_i && (complete_id_i == ID_W'(i));
    end
  end

  for (genvar g = 1; g <= IRQ_CNT; g++) begin : g_cell
    plic_gw_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .src       (src_i[g]),
      .edge_mode (edge_i[g]),
      .claim     (claim_oh[g]),
      .complete  (complete_oh[g]),
      .irq       (irq_o[g])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: directed scenarios plus a randomized
// run, all compared against a behavioural per-source model.
module tb_plic_gateway;

  localparam int N   = 8;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N:1]     src;
  logic [N:1]     edge_m;
  logic           claim;
  logic [IDW-1:0] claim_id;
  logic           complete;
  logic [IDW-1:0] complete_id;
  logic [N:1]     irq;

  int checks   = 0;
  int failures = 0;

  // Model: sampled history of each line plus request/service/banked-edge flags.
  bit h1 [1:N];
  bit h2 [1:N];
  bit h3 [1:N];
  bit m_pend [1:N];
  bit m_clm  [1:N];
  bit m_buf  [1:N];

  plic_gateway #(.IRQ_CNT(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_i         (src),
    .edge_i        (edge_m),
    .claim_i       (claim),
    .claim_id_i    (claim_id),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    for (int i = 1; i <= N; i++) begin
      bit rise, trig, hit_c, hit_p;
      if (reset) begin
        h1[i] = 0; h2[i] = 0; h3[i] = 0;
        m_pend[i] = 0; m_clm[i] = 0; m_buf[i] = 0;
      end else begin
        rise  = h2[i] && !h3[i];
        trig  = edge_m[i] ? rise : h2[i];
        hit_c = claim    && (int'(claim_id)    == i);
        hit_p = complete && (int'(complete_id) == i);
        if (m_pend[i]) begin
          if (hit_c) begin m_pend[i] = 0; m_clm[i] = 1; end
        end else if (m_clm[i]) begin
          if (hit_p) begin
            m_clm[i]  = 0;
            m_pend[i] = edge_m[i] ? (m_buf[i] || rise) : h2[i];
            m_buf[i]  = 0;
          end else if (edge_m[i] && rise) begin
            m_buf[i] = 1;
          end
        end else if (trig) begin
          m_pend[i] = 1;
        end
        if (!edge_m[i]) m_buf[i] = 0;
        h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = src[i];
      end
    end
  endtask

  function automatic logic [N:1] model_irq();
    logic [N:1] r;
    for (int i = 1; i <= N; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; src = '0; claim = 1'b0; complete = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_claim(input int id);
    claim = 1'b1; claim_id = IDW'(id);
    tick();
    claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1; complete_id = IDW'(id);
    tick();
    complete = 1'b0;
  endtask

  task automatic pulse(input int id);
    src[id] = 1'b1;
    tick();
    src[id] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = N'($urandom); edge_m = N'($urandom);
    tick();
    checks++;
    if (irq !== '0) begin failures++; $display("FAIL reset_first irq=%h exp=00", irq); end
    repeat (3) tick();
    checks++;
    if (irq !== '0) begin failures++; $display("FAIL reset_hold irq=%h exp=00", irq); end
    // Level source held high through reset re-requests on the third edge after release.
    src = '0; src[1] = 1'b1; edge_m = '0;
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (irq !== ((c == 3) ? N'(1) : N'(0))) begin
        failures++; $display("FAIL reset_rereq c=%0d irq=%h exp=%h", c, irq, (c == 3) ? N'(1) : N'(0));
      end
    end
    do_reset();
  endtask

  task automatic test_level();
    edge_m = '0; src = '0; src[3] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (irq[3] !== (c == 3)) begin
        failures++; $display("FAIL level_latency c=%0d irq3=%b exp=%b", c, irq[3], c == 3);
      end
    end
    do_claim(3);
    checks++;
    if (irq[3] !== 1'b0) begin failures++; $display("FAIL level_claim irq3=%b exp=0", irq[3]); end
    do_complete(3);
    checks++;
    if (irq[3] !== 1'b1) begin failures++; $display("FAIL level_rereq irq3=%b exp=1", irq[3]); end
    checks++;
    if (irq !== model_irq()) begin failures++; $display("FAIL level_model irq=%h exp=%h", irq, model_irq()); end
    do_reset();
  endtask

  task automatic test_edge();
    edge_m = '0; edge_m[5] = 1'b1; src = '0;
    pulse(5); tick(); tick();
    checks++;
    if (irq[5] !== 1'b1) begin failures++; $display("FAIL edge_rise irq5=%b exp=1", irq[5]); end
    repeat (8) tick();
    checks++;
    if (irq[5] !== 1'b1) begin failures++; $display("FAIL edge_hold irq5=%b exp=1", irq[5]); end
    do_claim(5);
    checks++;
    if (irq[5] !== 1'b0) begin failures++; $display("FAIL edge_claim irq5=%b exp=0", irq[5]); end
    repeat (2) begin pulse(5); repeat (3) tick(); end
    checks++;
    if (irq[5] !== 1'b0) begin failures++; $display("FAIL edge_claimed_quiet irq5=%b exp=0", irq[5]); end
    do_complete(5);
    checks++;
    if (irq[5] !== 1'b1) begin failures++; $display("FAIL edge_buf_rereq irq5=%b exp=1", irq[5]); end
    do_claim(5); do_complete(5);
    repeat (5) tick();
    checks++;
    if (irq[5] !== 1'b0) begin failures++; $display("FAIL edge_single_rereq irq5=%b exp=0", irq[5]); end
    do_reset();
  endtask

  task automatic test_invalid_ids();
    logic [N:1] exp;
    int bad [4];
    edge_m = '0; src = '0; src[2] = 1'b1;
    repeat (4) tick();
    exp = '0; exp[2] = 1'b1;
    bad[0] = 0; bad[1] = N + 1; bad[2] = 15; bad[3] = 0;
    for (int k = 0; k < 3; k++) begin
      do_claim(bad[k]);
      checks++;
      if (irq !== exp) begin failures++; $display("FAIL bad_claim id=%0d irq=%h exp=%h", bad[k], irq, exp); end
    end
    do_complete(2);
    do_complete(1);
    checks++;
    if (irq !== exp) begin failures++; $display("FAIL bad_complete irq=%h exp=%h", irq, exp); end
    do_claim(2);
    checks++;
    if (irq !== '0) begin failures++; $display("FAIL valid_claim irq=%h exp=00", irq); end
    do_reset();
  endtask

  task automatic test_same_cycle();
    logic [N:1] exp;
    edge_m = '0; src = '0; src[2] = 1'b1; src[4] = 1'b1;
    repeat (4) tick();
    do_claim(4);
    exp = '0; exp[2] = 1'b1;
    checks++;
    if (irq !== exp) begin failures++; $display("FAIL same_setup irq=%h exp=%h", irq, exp); end
    claim = 1'b1; claim_id = IDW'(2); complete = 1'b1; complete_id = IDW'(4);
    tick();
    claim = 1'b0; complete = 1'b0;
    exp = '0; exp[4] = 1'b1;
    checks++;
    if (irq !== exp) begin failures++; $display("FAIL same_cycle irq=%h exp=%h", irq, exp); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    edge_m = '0; edge_m[1] = 1'b1; edge_m[6] = 1'b1; src = '0;
    src[1] = 1'b1; src[6] = 1'b1; tick(); src = '0;
    tick(); tick();
    do_claim(1);
    pulse(1); repeat (3) tick();
    checks++;
    if (irq !== model_irq()) begin failures++; $display("FAIL mid_setup irq=%h exp=%h", irq, model_irq()); end
    reset = 1'b1;
    tick();
    checks++;
    if (irq !== '0) begin failures++; $display("FAIL mid_reset irq=%h exp=00", irq); end
    reset = 1'b0;
    do_complete(1);
    repeat (5) tick();
    checks++;
    if (irq !== '0) begin failures++; $display("FAIL mid_spurious irq=%h exp=00", irq); end
    do_reset();
  endtask

  task automatic test_mode_change();
    edge_m = '0; edge_m[7] = 1'b1; src = '0;
    pulse(7); tick(); tick();
    checks++;
    if (irq[7] !== 1'b1) begin failures++; $display("FAIL mode_pend irq7=%b exp=1", irq[7]); end
    do_claim(7);
    pulse(7); repeat (3) tick();
    edge_m[7] = 1'b0;
    tick();
    do_complete(7);
    checks++;
    if (irq[7] !== 1'b0) begin failures++; $display("FAIL mode_complete irq7=%b exp=0", irq[7]); end
    repeat (4) tick();
    checks++;
    if (irq[7] !== 1'b0) begin failures++; $display("FAIL mode_idle irq7=%b exp=0", irq[7]); end
    do_reset();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      src         = src ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) edge_m = N'($urandom);
      claim       = ($urandom_range(0, 2) == 0);
      claim_id    = IDW'($urandom_range(0, 15));
      complete    = ($urandom_range(0, 2) == 0);
      complete_id = IDW'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (irq !== model_irq()) begin
        failures++;
        if (errs < 10) $display("FAIL random c=%0d irq=%h exp=%h", c, irq, model_irq());
        errs++;
      end
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1; src = '0; edge_m = '0;
    claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
    do_reset();
    test_reset();
    test_level();
    test_edge();
    test_invalid_ids();
    test_same_cycle();
    test_reset_mid();
    test_mode_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
